pla_eval_sequencer: RTL and testbench

- Sequential stage placed directly upstream of a combinational single-output PLA slice (15 inputs x0..x14, one output y0).
- Accepts 15-bit input vectors over a valid/ready handshake and holds each vector stable on the slice inputs for a programmable settle time.
- Samples the slice output, returns the vector and its result over a second valid/ready handshake, and keeps a saturating count of vectors that evaluated to 1.

---
 rtl/pla_eval_sequencer.sv | 132 +++++++++++++
 tb/tb_pla_eval_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_eval_sequencer.sv
// Drives a combinational PLA slice with handshaked 15-bit vectors, holds each one
// for a programmable settle time, then returns the sampled output and counts hits.
module pla_eval_sequencer #(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [14:0]      in_vec,
   output logic [14:0]      pla_x,
   input  logic             pla_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [14:0]      out_vec,
   output logic             out_y,
   input  logic             clr_count,
   output logic [CNT_W-1:0] hit_count
);
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [7:0]       CNT_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HIT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] HIT_ONE  = CNT_W'(1);

   state_t           state_r;
   state_t           state_s;
   logic [7:0]       cnt_r;
   logic [14:0]      pla_x_r;
   logic [14:0]      out_vec_r;
   logic             out_valid_r;
   logic             out_y_r;
   logic [CNT_W-1:0] hit_r;
   logic             in_ready_s;
   logic             accept_s;
   logic             sample_s;

   assign accept_s  = in_valid & in_ready_s;
   assign sample_s  = (state_r == DRIVE) && (cnt_r == 8'd0);

   assign in_ready  = in_ready_s;
   assign pla_x     = pla_x_r;
   assign out_valid = out_valid_r;
   assign out_vec   = out_vec_r;
   assign out_y     = out_y_r;
   assign hit_count = hit_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; HOLD can chain straight into DRIVE when a new vector waits
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = DRIVE;
            else          state_s = IDLE;
         end
         DRIVE: begin
            if (cnt_r == 8'd0) state_s = HOLD;
            else               state_s = DRIVE;
         end
         HOLD: begin
            if (out_ready) begin
               if (in_valid) state_s = DRIVE;
               else          state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Output decode; in_ready stays low for as long as reset is held
   always_comb begin
      in_ready_s = 1'b0;
      if (!rst_n) begin
         in_ready_s = 1'b0;
      end else begin
         case (state_r)
            IDLE:    in_ready_s = 1'b1;
            HOLD:    in_ready_s = out_ready;
            DRIVE:   in_ready_s = 1'b0;
            default: in_ready_s = 1'b0;
         endcase
      end
   end

   // Slice drive, settle counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pla_x_r     <= 15'd0;
         cnt_r       <= 8'd0;
         out_vec_r   <= 15'd0;
         out_y_r     <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            pla_x_r <= in_vec;
            cnt_r   <= CNT_LOAD;
         end else if ((state_r == DRIVE) && (cnt_r != 8'd0)) begin
            cnt_r <= cnt_r - 8'd1;
         end
         if (sample_s) begin
            out_valid_r <= 1'b1;
            out_y_r     <= pla_y;
            out_vec_r   <= pla_x_r;
         end else if ((state_r == HOLD) && out_ready) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Saturating hit counter; a clear overrides a coincident increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_r <= '0;
      end else if (clr_count) begin
         hit_r <= '0;
      end else if (sample_s && pla_y && (hit_r != HIT_MAX)) begin
         hit_r <= hit_r + HIT_ONE;
      end
   end
endmodule

// File: tb/tb_pla_eval_sequencer.sv
// Bench for pla_eval_sequencer: three instances (settle 1, settle 4, 2-bit counter)
// share their inputs; each scenario checks one instance against a rule-based model.
module tb_pla_eval_sequencer;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [14:0]      in_vec = 15'd0;
   logic             out_ready = 1'b0;
   logic             clr_count = 1'b0;
   logic [2:0]       in_ready_m;
   logic [2:0]       out_valid_m;
   logic [2:0]       out_y_m;
   logic [2:0]       pla_y_m;
   logic [2:0][14:0] pla_x_m;
   logic [2:0][14:0] out_vec_m;
   logic [2:0][15:0] hit_m;
   logic [15:0]      hc0;
   logic [15:0]      hc1;
   logic [1:0]       hc2;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_hit [3];
   int max_hit [3] = '{65535, 65535, 3};

   always #5 clk = ~clk;

   // PLA slice model: y0 = x2 ^ x8, and only when every other input is 0
   function automatic logic pla_rule(input logic [14:0] x);
      return (x[2] ^ x[8]) && ((x & 15'h7EFB) == 15'd0);
   endfunction

   assign pla_y_m[0] = pla_rule(pla_x_m[0]);
   assign pla_y_m[1] = pla_rule(pla_x_m[1]);
   assign pla_y_m[2] = pla_rule(pla_x_m[2]);
   assign hit_m[0]   = hc0;
   assign hit_m[1]   = hc1;
   assign hit_m[2]   = {14'd0, hc2};

   pla_eval_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) u_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m[0]),
      .in_vec(in_vec), .pla_x(pla_x_m[0]), .pla_y(pla_y_m[0]), .out_valid(out_valid_m[0]),
      .out_ready(out_ready), .out_vec(out_vec_m[0]), .out_y(out_y_m[0]),
      .clr_count(clr_count), .hit_count(hc0));

   pla_eval_sequencer #(.SETTLE_CYCLES(4), .CNT_W(16)) u_s4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m[1]),
      .in_vec(in_vec), .pla_x(pla_x_m[1]), .pla_y(pla_y_m[1]), .out_valid(out_valid_m[1]),
      .out_ready(out_ready), .out_vec(out_vec_m[1]), .out_y(out_y_m[1]),
      .clr_count(clr_count), .hit_count(hc1));

   pla_eval_sequencer #(.SETTLE_CYCLES(1), .CNT_W(2)) u_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m[2]),
      .in_vec(in_vec), .pla_x(pla_x_m[2]), .pla_y(pla_y_m[2]), .out_valid(out_valid_m[2]),
      .out_ready(out_ready), .out_vec(out_vec_m[2]), .out_y(out_y_m[2]),
      .clr_count(clr_count), .hit_count(hc2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_hit(input int k, input logic [14:0] v);
      if (pla_rule(v) && exp_hit[k] < max_hit[k]) exp_hit[k]++;
   endtask

   // Accept v on instance k (which must be idle) and follow it until the result shows
   task automatic drive_to_hold(input int k, input logic [14:0] v, input int s);
      in_vec = v; in_valid = 1'b1; out_ready = 1'b0;
      step();
      chk("accept_pla_x", pla_x_m[k], v);
      in_valid = 1'b0;
      in_vec = 15'($urandom);
      for (int i = 0; i < s; i++) begin
         chk("drive_out_valid", out_valid_m[k], 1'b0);
         chk("drive_in_ready", in_ready_m[k], 1'b0);
         chk("drive_pla_x", pla_x_m[k], v);
         step();
      end
      chk("result_valid", out_valid_m[k], 1'b1);
      chk("result_y", out_y_m[k], pla_rule(v));
      chk("result_vec", out_vec_m[k], v);
      count_hit(k, v);
   endtask

   // Stall the result for hold cycles, then complete the output handshake
   task automatic hold_and_release(input int k, input logic [14:0] v, input int hold);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("stall_valid", out_valid_m[k], 1'b1);
         chk("stall_vec", out_vec_m[k], v);
         chk("stall_y", out_y_m[k], pla_rule(v));
         chk("stall_in_ready", in_ready_m[k], 1'b0);
      end
      out_ready = 1'b1;
      #1;
      chk("hold_in_ready", in_ready_m[k], 1'b1);
      step();
      out_ready = 1'b0;
      chk("released_valid", out_valid_m[k], 1'b0);
      chk("hit_count", hit_m[k], exp_hit[k]);
   endtask

   task automatic send_and_check(input int k, input logic [14:0] v, input int s, input int hold);
      drive_to_hold(k, v, s);
      hold_and_release(k, v, hold);
   endtask

   // Bring every instance back to IDLE with cleared counters
   task automatic drain();
      in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b1;
      repeat (8) step();
      clr_count = 1'b0; out_ready = 1'b0;
      for (int k = 0; k < 3; k++) exp_hit[k] = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] seq [4] = '{15'h0100, 15'h0000, 15'h0104, 15'h0005};
      logic [14:0] v;
      int s_of [3] = '{1, 4, 1};
      for (int k = 0; k < 3; k++) exp_hit[k] = 0;

      // Reset values
      repeat (2) step();
      chk("rst_in_ready", in_ready_m[0], 1'b0);
      chk("rst_pla_x", pla_x_m[0], 15'd0);
      chk("rst_out_valid", out_valid_m[0], 1'b0);
      chk("rst_out_vec", out_vec_m[0], 15'd0);
      chk("rst_out_y", out_y_m[0], 1'b0);
      chk("rst_hit", hit_m[0], 16'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready_m[0], 1'b1);

      // 1: first vector after reset
      send_and_check(0, 15'h0004, 1, 0);

      // 2: back-to-back stream with out_ready and in_valid held high
      drain();
      in_vec = seq[0]; in_valid = 1'b1; out_ready = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("stream_pla_x", pla_x_m[0], seq[i]);
         chk("stream_drive_in_ready", in_ready_m[0], 1'b0);
         chk("stream_drive_valid", out_valid_m[0], 1'b0);
         if (i < 3) in_vec = seq[i+1];
         step();
         chk("stream_valid", out_valid_m[0], 1'b1);
         chk("stream_y", out_y_m[0], pla_rule(seq[i]));
         chk("stream_vec", out_vec_m[0], seq[i]);
         chk("stream_hold_in_ready", in_ready_m[0], 1'b1);
         count_hit(0, seq[i]);
         if (i == 3) in_valid = 1'b0;
         step();
      end
      chk("stream_end_valid", out_valid_m[0], 1'b0);
      chk("stream_hit", hit_m[0], 16'd1);
      out_ready = 1'b0;

      // 3: settle time of 4
      drain();
      send_and_check(1, 15'h0004, 4, 2);

      // 4: backpressure with a pending vector
      drain();
      drive_to_hold(0, 15'h0004, 1);
      in_vec = 15'h0100; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_valid", out_valid_m[0], 1'b1);
         chk("bp_vec", out_vec_m[0], 15'h0004);
         chk("bp_y", out_y_m[0], 1'b1);
         chk("bp_in_ready", in_ready_m[0], 1'b0);
         chk("bp_pla_x", pla_x_m[0], 15'h0004);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", in_ready_m[0], 1'b1);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("bp_handshake_valid", out_valid_m[0], 1'b0);
      chk("bp_accept_pla_x", pla_x_m[0], 15'h0100);
      chk("bp_accept_in_ready", in_ready_m[0], 1'b0);
      step();
      chk("bp_next_valid", out_valid_m[0], 1'b1);
      chk("bp_next_y", out_y_m[0], 1'b1);
      chk("bp_next_vec", out_vec_m[0], 15'h0100);
      count_hit(0, 15'h0100);
      hold_and_release(0, 15'h0100, 0);

      // 5: 2-bit counter saturation, then clear colliding with a hit
      drain();
      for (int i = 0; i < 5; i++) send_and_check(2, 15'h0004, 1, 0);
      chk("sat_hit", hit_m[2], 16'd3);
      in_vec = 15'h0004; in_valid = 1'b1;
      step();
      in_valid = 1'b0; clr_count = 1'b1;
      step();
      clr_count = 1'b0;
      exp_hit[2] = 0;
      chk("clr_vs_hit_valid", out_valid_m[2], 1'b1);
      chk("clr_vs_hit", hit_m[2], 16'd0);
      hold_and_release(2, 15'h0004, 0);

      // 6: reset in the middle of DRIVE
      drain();
      send_and_check(1, 15'h0004, 4, 0);
      in_vec = 15'h0004; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_pla_x", pla_x_m[1], 15'd0);
      chk("midrst_valid", out_valid_m[1], 1'b0);
      chk("midrst_hit", hit_m[1], 16'd0);
      chk("midrst_in_ready", in_ready_m[1], 1'b0);
      for (int k = 0; k < 3; k++) exp_hit[k] = 0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("midrst_no_stale", out_valid_m[1], 1'b0);
      end
      chk("midrst_idle_ready", in_ready_m[1], 1'b1);
      send_and_check(1, 15'h0004, 4, 1);

      // Randomized vectors on every instance against the rule model
      for (int k = 0; k < 3; k++) begin
         drain();
         for (int t = 0; t < 8; t++) begin
            case ($urandom_range(0, 2))
               0: v = 15'($urandom);
               1: begin
                  v = 15'd0;
                  v[2] = 1'($urandom);
                  v[8] = 1'($urandom);
               end
               default: begin
                  v = 15'd0;
                  v[2] = 1'b1;
                  v[$urandom_range(0, 14)] = 1'b1;
               end
            endcase
            send_and_check(k, v, s_of[k], int'($urandom_range(0, 3)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
